// File: rtl/ram_pattern_checker.sv
// ram_pattern_checker
// Sweeps a single-port RAM from address 0 to ADDR_MAX. Each location must
// hold SEED rotated left by (address mod 8). The block counts mismatching
// addresses, records the first bad address and the data read there, and
// reports pass/fail when the sweep ends.
//
// Ports
//   clk_in         : single clock, rising edge
//   reset          : synchronous, active-high reset
//   start          : one-cycle request to begin a pass (taken in IDLE/DONE)
//   ram_dout       : RAM read data, READ_LAT cycles after the address
//   ram_ad         : RAM address (0 when not sweeping)
//   ram_ce         : RAM clock enable (1 in RUN and DRAIN)
//   ram_wre        : RAM write enable, always 0
//   busy           : pass in progress
//   done           : pass finished; holds until the next accepted start
//   pass           : valid with done, 1 when no mismatch was seen
//   err_count      : mismatching addresses in the current/last pass
//   first_err_addr : address of the first mismatch
//   first_err_data : data read at the first mismatch
module ram_pattern_checker #(
    parameter int                ADDR_W   = 11,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] ADDR_MAX = 11'd2047,
    parameter logic [DATA_W-1:0] SEED     = 8'b1111_1110,
    parameter int                READ_LAT = 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [ADDR_W-1:0] ram_ad,
    output logic              ram_ce,
    output logic              ram_wre,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // err_count saturates at the number of addresses in one sweep
    localparam logic [ADDR_W:0]   ERR_MAX    = {1'b0, ADDR_MAX} + {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   ERR_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]        DRAIN_LAST = 2'(READ_LAT - 1);

    state_t              state;
    state_t              next_state;
    logic                accept;
    logic                issue;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [1:0]          drain_cnt;
    logic                mismatch;
    logic                done_r;
    logic                pass_r;

    // Pipeline carrying each issued address alongside the byte it should
    // return, so the compare lines up with ram_dout READ_LAT cycles later.
    logic [READ_LAT-1:0] vld_pipe;
    logic [ADDR_W-1:0]   addr_pipe [READ_LAT];
    logic [DATA_W-1:0]   exp_pipe  [READ_LAT];

    // Expected pattern: SEED rotated left by the low three address bits
    function automatic logic [DATA_W-1:0] rotl_seed(input logic [2:0] amount);
        logic [2*DATA_W-1:0] doubled;
        doubled = {SEED, SEED} << amount;
        return doubled[2*DATA_W-1 -: DATA_W];
    endfunction

    assign mismatch = vld_pipe[READ_LAT-1] && (ram_dout != exp_pipe[READ_LAT-1]);
    assign ram_wre  = 1'b0;
    assign done     = done_r;
    assign pass     = pass_r;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Reset also gates the decode so a start coincident with reset is
    // never accepted and the RAM interface goes quiet immediately.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        issue      = 1'b0;
        busy       = 1'b0;
        ram_ce     = 1'b0;
        ram_ad     = '0;
        if (!reset) begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        next_state = RUN;
                        accept     = 1'b1;
                    end
                end
                RUN: begin
                    busy   = 1'b1;
                    ram_ce = 1'b1;
                    ram_ad = addr_cnt;
                    issue  = 1'b1;
                    if (addr_cnt == ADDR_MAX) begin
                        next_state = DRAIN;
                    end
                end
                DRAIN: begin
                    busy   = 1'b1;
                    ram_ce = 1'b1;
                    if (drain_cnt == DRAIN_LAST) begin
                        next_state = DONE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // done/pass are loaded in the first DONE cycle, one edge after the
    // final compare has landed in err_count, so pass reflects every address.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            addr_cnt       <= '0;
            drain_cnt      <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            done_r         <= 1'b0;
            pass_r         <= 1'b0;
            vld_pipe       <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                addr_pipe[i] <= '0;
                exp_pipe[i]  <= '0;
            end
        end else begin
            vld_pipe[0]  <= issue;
            addr_pipe[0] <= addr_cnt;
            exp_pipe[0]  <= rotl_seed(addr_cnt[2:0]);
            for (int i = 1; i < READ_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
                exp_pipe[i]  <= exp_pipe[i-1];
            end

            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 2'd1;
            end else begin
                drain_cnt <= '0;
            end

            if (accept) begin
                addr_cnt       <= '0;
                err_count      <= '0;
                first_err_addr <= '0;
                first_err_data <= '0;
                done_r         <= 1'b0;
                pass_r         <= 1'b0;
            end else begin
                if (state == RUN) begin
                    addr_cnt <= addr_cnt + ADDR_ONE;
                end
                if (mismatch) begin
                    if (err_count != ERR_MAX) begin
                        err_count <= err_count + ERR_ONE;
                    end
                    if (err_count == '0) begin
                        first_err_addr <= addr_pipe[READ_LAT-1];
                        first_err_data <= ram_dout;
                    end
                end
                if (state == DONE) begin
                    done_r <= 1'b1;
                    pass_r <= (err_count == '0);
                end
            end
        end
    end

endmodule
